// File: rtl/regfile_seq_pkg.sv
// rtl/regfile_seq_pkg.sv - shared types and encodings for the register-file sequencer
package regfile_seq_pkg;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_MOVI   = 3'd2,
      S_READ   = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV  = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_CMP = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_MVN = 2'b11;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

endpackage

// File: rtl/regfile_seq_if.sv
// rtl/regfile_seq_if.sv - instruction handshake and datapath control bundle
interface regfile_seq_if #(
   parameter int DW = 16,
   parameter int RW = 3
);
   logic          start;
   logic [DW-1:0] instr;
   logic          w;
   logic          rf_write;
   logic [RW-1:0] rf_reg_w;
   logic [RW-1:0] rf_reg_a;
   logic [RW-1:0] rf_reg_b;
   logic          loada;
   logic          loadb;
   logic          loadc;
   logic          loads;
   logic          asel;
   logic          bsel;
   logic [1:0]    vsel;
   logic [1:0]    alu_op;
   logic [1:0]    shift;
   logic [DW-1:0] sximm8;
   logic          illegal;

   modport master (
      output start, instr,
      input  w, rf_write, rf_reg_w, rf_reg_a, rf_reg_b,
      input  loada, loadb, loadc, loads, asel, bsel, vsel,
      input  alu_op, shift, sximm8, illegal
   );

   modport slave (
      input  start, instr,
      output w, rf_write, rf_reg_w, rf_reg_a, rf_reg_b,
      output loada, loadb, loadc, loads, asel, bsel, vsel,
      output alu_op, shift, sximm8, illegal
   );
endinterface

// File: rtl/regfile_seq_decode.sv
// rtl/regfile_seq_decode.sv - combinational field extraction and legality decode of IR
module seq_decode
   import regfile_seq_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic [DW-1:0] ir,
   output logic          is_movi,
   output logic          is_mov,
   output logic          is_alu,
   output logic          is_cmp,
   output logic          uses_a,
   output logic          illegal_enc,
   output logic [1:0]    op,
   output logic [1:0]    shift,
   output logic [RW-1:0] rn,
   output logic [RW-1:0] rd,
   output logic [RW-1:0] rm,
   output logic [DW-1:0] sximm8
);
   logic [2:0] opcode;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign rm     = ir[2:0];
   assign shift  = ir[4:3];
   assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};

   assign is_movi     = (opcode == OPC_MOV) && (op == OP_MOVI);
   assign is_mov      = (opcode == OPC_MOV) && (op == OP_MOV);
   assign is_alu      = (opcode == OPC_ALU);
   assign is_cmp      = is_alu && (op == ALU_CMP);
   // MVN only needs Rm; MOV is handled separately by the caller
   assign uses_a      = is_alu && (op != ALU_MVN);
   assign illegal_enc = !(is_movi || is_mov || is_alu);
endmodule

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - Moore sequencer driving regfile selects and datapath controls
module regfile_seq
   import regfile_seq_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_seq_if.slave bus
);
   state_t        state, state_nx;
   logic [DW-1:0] ir;

   logic          is_movi, is_mov, is_alu, is_cmp, uses_a, illegal_enc;
   logic [1:0]    op, shift_d;
   logic [RW-1:0] rn, rd, rm;
   logic [DW-1:0] sximm8_d;

   logic          w_c, rf_write_c, loada_c, loadb_c, loadc_c, loads_c;
   logic          asel_c, illegal_c;
   logic [RW-1:0] rf_reg_w_c, rf_reg_a_c, rf_reg_b_c;
   logic [1:0]    vsel_c, alu_op_c;

   seq_decode #(.DW(DW), .RW(RW)) u_decode (
      .ir          (ir),
      .is_movi     (is_movi),
      .is_mov      (is_mov),
      .is_alu      (is_alu),
      .is_cmp      (is_cmp),
      .uses_a      (uses_a),
      .illegal_enc (illegal_enc),
      .op          (op),
      .shift       (shift_d),
      .rn          (rn),
      .rd          (rd),
      .rm          (rm),
      .sximm8      (sximm8_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if (state == S_WAIT && bus.start)
            ir <= bus.instr;
      end
   end

   always_comb begin
      state_nx   = state;
      w_c        = 1'b0;
      rf_write_c = 1'b0;
      rf_reg_w_c = '0;
      rf_reg_a_c = '0;
      rf_reg_b_c = '0;
      loada_c    = 1'b0;
      loadb_c    = 1'b0;
      loadc_c    = 1'b0;
      loads_c    = 1'b0;
      asel_c     = 1'b0;
      vsel_c     = VSEL_C;
      alu_op_c   = ALU_ADD;
      illegal_c  = 1'b0;
      case (state)
         S_WAIT: begin
            w_c = 1'b1;
            if (bus.start)
               state_nx = S_DECODE;
         end
         S_DECODE: begin
            if (is_movi)
               state_nx = S_MOVI;
            else if (is_alu || is_mov)
               state_nx = S_READ;
            else begin
               state_nx  = S_WAIT;
               illegal_c = illegal_enc;
            end
         end
         S_MOVI: begin
            rf_write_c = 1'b1;
            rf_reg_w_c = rn;
            vsel_c     = VSEL_IMM;
            state_nx   = S_WAIT;
         end
         S_READ: begin
            rf_reg_a_c = rn;
            rf_reg_b_c = rm;
            loada_c    = uses_a;
            loadb_c    = 1'b1;
            state_nx   = S_EXEC;
         end
         S_EXEC: begin
            // MOV is ADD with the A operand forced to zero
            alu_op_c = is_mov ? ALU_ADD : op;
            asel_c   = is_mov;
            if (is_cmp) begin
               loads_c  = 1'b1;
               state_nx = S_WAIT;
            end else begin
               loadc_c  = 1'b1;
               state_nx = S_WB;
            end
         end
         S_WB: begin
            rf_write_c = 1'b1;
            rf_reg_w_c = rd;
            vsel_c     = VSEL_C;
            state_nx   = S_WAIT;
         end
         default: state_nx = S_WAIT;
      endcase
   end

   // Strobes are masked by reset so an in-flight write or load is dropped
   assign bus.rf_write = rf_write_c & rst_n;
   assign bus.loada    = loada_c & rst_n;
   assign bus.loadb    = loadb_c & rst_n;
   assign bus.loadc    = loadc_c & rst_n;
   assign bus.loads    = loads_c & rst_n;
   assign bus.illegal  = illegal_c & rst_n;

   assign bus.w        = w_c;
   assign bus.rf_reg_w = rf_reg_w_c;
   assign bus.rf_reg_a = rf_reg_a_c;
   assign bus.rf_reg_b = rf_reg_b_c;
   assign bus.asel     = asel_c;
   assign bus.bsel     = 1'b0;
   assign bus.vsel     = vsel_c;
   assign bus.alu_op   = alu_op_c;
   assign bus.shift    = shift_d;
   assign bus.sximm8   = sximm8_d;
endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - directed vector bench for regfile_seq with a small datapath model
module tb_regfile_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   regfile_seq_if #(.DW(16), .RW(3)) bus ();

   regfile_seq #(.DW(16), .RW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Register file plus A/B/C datapath driven by the sequencer controls
   logic [15:0] regs [8];
   logic [15:0] ra_q, rb_q, rc_q, aop;

   always_comb aop = bus.asel ? 16'h0 : ra_q;

   always @(posedge clk) begin
      if (bus.rf_write)
         regs[bus.rf_reg_w] <= (bus.vsel == 2'b01) ? bus.sximm8 : rc_q;
      if (bus.loada) ra_q <= regs[bus.rf_reg_a];
      if (bus.loadb) rb_q <= regs[bus.rf_reg_b];
      if (bus.loadc) begin
         case (bus.alu_op)
            2'b00:   rc_q <= aop + rb_q;
            2'b01:   rc_q <= aop - rb_q;
            2'b10:   rc_q <= aop & rb_q;
            default: rc_q <= ~rb_q;
         endcase
      end
   end

   typedef struct {
      logic [15:0] instr;
      int          lat;
      logic        wr;
      logic [2:0]  wreg;
      logic [1:0]  wvsel;
      logic        la;
      logic        lb;
      logic        lc;
      logic        ls;
      logic        ill;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [1:0]  aop;
      logic        as;
   } vec_t;

   vec_t vecs [9];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int         lat;
      logic       o_wr, o_la, o_lb, o_lc, o_ls, o_as;
      int         n_ill;
      logic [2:0] o_wreg, o_ra, o_rb;
      logic [1:0] o_vsel, o_aop;
      string      tag;
      o_wr = 0; o_la = 0; o_lb = 0; o_lc = 0; o_ls = 0; o_as = 0; n_ill = 0;
      o_wreg = 0; o_ra = 0; o_rb = 0; o_vsel = 0; o_aop = 0;
      tag = $sformatf("v%0d_%h", idx, v.instr);
      bus.instr = v.instr;
      bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      lat = 1;
      while (bus.w !== 1'b1 && lat < 12) begin
         if (bus.rf_write) begin o_wr = 1; o_wreg = bus.rf_reg_w; o_vsel = bus.vsel; end
         if (bus.loada) o_la = 1;
         if (bus.loadb) begin o_lb = 1; o_ra = bus.rf_reg_a; o_rb = bus.rf_reg_b; end
         if (bus.loadc || bus.loads) begin o_aop = bus.alu_op; o_as = bus.asel; end
         if (bus.loadc) o_lc = 1;
         if (bus.loads) o_ls = 1;
         if (bus.illegal) n_ill++;
         step;
         lat++;
      end
      chk({tag, " latency"}, lat, v.lat);
      chk({tag, " rf_write"}, o_wr, v.wr);
      chk({tag, " loads_flags"}, {o_la, o_lb, o_lc, o_ls}, {v.la, v.lb, v.lc, v.ls});
      chk({tag, " illegal_cycles"}, n_ill, v.ill ? 1 : 0);
      if (v.wr) chk({tag, " wb_sel"}, {o_wreg, o_vsel}, {v.wreg, v.wvsel});
      if (v.lb) chk({tag, " read_idx"}, {o_ra, o_rb}, {v.ra, v.rb});
      if (v.lc || v.ls) chk({tag, " alu"}, {o_aop, o_as}, {v.aop, v.as});
   endtask

   initial begin
      int          lat;
      logic [15:0] saved;
      vecs[0] = '{16'hD2F6, 3, 1, 3'd2, 2'b01, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'b00, 0};
      vecs[1] = '{16'hA0A1, 5, 1, 3'd5, 2'b00, 1, 1, 1, 0, 0, 3'd0, 3'd1, 2'b00, 0};
      vecs[2] = '{16'hA900, 4, 0, 3'd0, 2'b00, 1, 1, 0, 1, 0, 3'd1, 3'd0, 2'b01, 0};
      vecs[3] = '{16'hB8E3, 5, 1, 3'd7, 2'b00, 0, 1, 1, 0, 0, 3'd0, 3'd3, 2'b11, 0};
      vecs[4] = '{16'hE000, 2, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 0};
      vecs[5] = '{16'hC0C4, 5, 1, 3'd6, 2'b00, 0, 1, 1, 0, 0, 3'd0, 3'd4, 2'b00, 1};
      vecs[6] = '{16'hB265, 5, 1, 3'd3, 2'b00, 1, 1, 1, 0, 0, 3'd2, 3'd5, 2'b10, 0};
      vecs[7] = '{16'hC800, 2, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 0};
      vecs[8] = '{16'hD800, 2, 0, 3'd0, 2'b00, 0, 0, 0, 0, 1, 3'd0, 3'd0, 2'b00, 0};

      for (int i = 0; i < 8; i++) regs[i] = 16'h0;
      ra_q = 0; rb_q = 0; rc_q = 0;
      bus.start = 1'b0;
      bus.instr = 16'h0;
      rst_n = 1'b0;
      step; step;
      rst_n = 1'b1;
      #1;
      chk("reset w", bus.w, 1);
      chk("reset strobes", {bus.rf_write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.illegal}, 0);
      chk("reset ir", {bus.sximm8, bus.shift}, 0);
      step;
      chk("idle w", bus.w, 1);

      // MOVI R2 cycle by cycle
      bus.instr = 16'hD2F6; bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      chk("movi decode", {bus.w, bus.rf_write}, 2'b00);
      chk("movi sximm8", bus.sximm8, 16'hFFF6);
      step;
      chk("movi write", {bus.rf_write, bus.rf_reg_w, bus.vsel}, {1'b1, 3'd2, 2'b01});
      step;
      chk("movi done", bus.w, 1);
      chk("movi regfile", regs[2], 16'hFFF6);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Start/instr toggling during an ADD must not disturb it
      bus.instr = 16'hA0A1; bus.start = 1'b1;
      step;
      lat = 1;
      while (bus.w !== 1'b1 && lat < 12) begin
         bus.start = lat[0];
         bus.instr = 16'hE000 ^ 16'(lat);
         #1;
         chk("toggle ir", {bus.sximm8, bus.shift}, {16'hFFA1, 2'b00});
         if (bus.rf_write) chk("toggle rd", bus.rf_reg_w, 5);
         step;
         lat++;
      end
      bus.start = 1'b0;
      chk("toggle latency", lat, 5);

      // Reset asserted in the WB cycle drops the write
      step;
      saved = regs[5] ^ 16'h0;
      regs[1] = 16'h1234;
      bus.instr = 16'hA0A1; bus.start = 1'b1;
      step;
      bus.start = 1'b0;
      step; step; step;
      chk("pre-reset wb", {bus.rf_write, bus.rf_reg_w}, {1'b1, 3'd5});
      saved = regs[5];
      rst_n = 1'b0;
      #1;
      chk("reset gates write", bus.rf_write, 0);
      step;
      rst_n = 1'b1;
      #1;
      chk("reset wb no commit", regs[5], saved);
      chk("reset wb state", {bus.w, bus.sximm8, bus.shift}, {1'b1, 16'h0, 2'b00});

      // Back-to-back: MOVI R3=5 then ADD R4=R3+R3 with start held
      step;
      bus.instr = 16'hD305; bus.start = 1'b1;
      step;
      bus.instr = 16'hA383;
      step;
      chk("b2b movi busy", bus.w, 0);
      step;
      chk("b2b wait", bus.w, 1);
      step;
      chk("b2b accepted", {bus.w, bus.sximm8}, {1'b0, 16'hFF83});
      bus.start = 1'b0;
      lat = 1;
      while (bus.w !== 1'b1 && lat < 12) begin
         step;
         lat++;
      end
      chk("b2b add latency", lat, 5);
      chk("b2b r3", regs[3], 16'h0005);
      chk("b2b r4", regs[4], 16'h000A);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
